// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings and Booth recoding helper for the iterative multiplier
package mul_pkg;
  typedef enum logic [1:0] {MUL_UU = 2'b00, MUL_SU = 2'b01, MUL_SS = 2'b11} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef struct packed {
    logic neg;
    logic zero;
    logic one;
    logic two;
  } booth_sel_t;
  function automatic booth_sel_t booth_decode(input logic [2:0] grp);
    booth_sel_t s;
    s.zero = (grp == 3'b000) | (grp == 3'b111);
    s.neg = grp[2];
    s.one = grp[1] ^ grp[0];
    s.two = (grp == 3'b011) | (grp == 3'b100);
    return s;
  endfunction
endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial product (inverted when negative, +1 supplied by caller)
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int N = 66
) (
  input  logic [2:0]   grp,
  input  logic [N-1:0] a_ext,
  output logic [N:0]   pp,
  output logic         neg
);
  booth_sel_t sel;
  logic [N:0] mag;
  // select 0, A or 2A, then one's-complement for the negative digits
  always_comb begin
    sel = booth_decode(grp);
    mag = ({(N+1){sel.one}} & {a_ext[N-1], a_ext}) | ({(N+1){sel.two}} & {a_ext, 1'b0});
    neg = sel.neg & ~sel.zero;
    pp = neg ? ~mag : mag;
  end
endmodule

// File: rtl/booth_iter_mul.sv
// booth_iter_mul: iterative radix-4 Booth multiplier with valid/ready handshakes and flush
module booth_iter_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int PP_PER_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);
  localparam int N = WIDTH + 2;
  localparam int GRP = N / 2;
  localparam int ITERS = (GRP + PP_PER_CYC - 1) / PP_PER_CYC;
  localparam int CW = $clog2(ITERS + 1);
  localparam int PW = 2 * WIDTH;
  state_t state, state_nx;
  logic [CW-1:0] iter_cnt;
  logic [N-1:0] a_reg;
  logic [N:0] b_sh;
  logic [PW-1:0] acc, acc_nx;
  logic [N:0] pp [PP_PER_CYC];
  logic [PP_PER_CYC-1:0] neg;
  logic accept, last, a_sgn, b_sgn;
  assign a_sgn = (in_mode == MUL_SU) || (in_mode == MUL_SS);
  assign b_sgn = in_mode == MUL_SS;
  assign in_ready = ~flush & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept = in_valid & in_ready;
  assign last = iter_cnt == CW'(ITERS - 1);
  assign out_valid = state == ST_DONE;
  assign out_prod = acc;
  for (genvar s = 0; s < PP_PER_CYC; s++) begin : g_pp
    booth_pp_gen #(.N(N)) u_pp (.grp(b_sh[2*s +: 3]), .a_ext(a_reg), .pp(pp[s]), .neg(neg[s]));
  end
  // add this cycle's shifted partial products; bits above 2*WIDTH never reach out_prod so the
  // sum is kept modulo 2^(2*WIDTH), and slots past the last Booth group contribute nothing
  always_comb begin
    acc_nx = acc;
    for (int k = 0; k < PP_PER_CYC; k++)
      if (int'(iter_cnt) * PP_PER_CYC + k < GRP)
        acc_nx = acc_nx + (({{(PW-N-1){pp[k][N]}}, pp[k]} + PW'(neg[k])) << (2 * (int'(iter_cnt) * PP_PER_CYC + k)));
  end
  // flush wins, then a new accept, then BUSY/DONE progression
  always_comb begin
    state_nx = flush ? ST_IDLE :
               accept ? ST_BUSY :
               (state == ST_BUSY && last) ? ST_DONE :
               (state == ST_DONE && out_ready) ? ST_IDLE : state;
  end
  // state, operand capture and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      iter_cnt <= '0;
      a_reg <= '0;
      b_sh <= '0;
      acc <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        iter_cnt <= '0;
        a_reg <= {{2{a_sgn & in_a[WIDTH-1]}}, in_a};
        b_sh <= {{2{b_sgn & in_b[WIDTH-1]}}, in_b, 1'b0};
        acc <= '0;
      end else if (state == ST_BUSY) begin
        iter_cnt <= iter_cnt + CW'(1);
        b_sh <= $signed(b_sh) >>> (2 * PP_PER_CYC);
        acc <= acc_nx;
      end
    end
  end
endmodule
